rob_ctrl: RTL and testbench
===========================

ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 Parameter DEPTH, 16, number of reorder-buffer entries (power of two).
REQ-002 Parameter IDX_W, 4, entry index width, log2(DEPTH).
REQ-003 Parameter CMPL_N, 3, number of completion ports, one per functional unit.
REQ-004 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_flush  input  1  discards all entries (pipeline flush).
REQ-007 i_alloc_req  input  2  allocation requests for lanes 0 and 1.
REQ-008 o_alloc_gnt  output  2  per-lane allocation grant, same cycle as request.
REQ-009 o_alloc_idx  output  2xIDX_W  entry index offered to lanes 0 and 1.
REQ-010 i_cmpl_valid  input  CMPL_N  per-port completion strobe.
REQ-011 i_cmpl_idx  input  CMPL_NxIDX_W  entry index completed on each port.
REQ-012 i_retire_stall  input  1  commit back-pressure; blocks all retirement.
REQ-013 o_retire_valid  output  2  per-slot retire strobe, in program order.
REQ-014 o_retire_idx  output  2xIDX_W  entry index retired on each slot.
REQ-015 o_count  output  IDX_W+1  number of occupied entries, range 0..DEPTH.
REQ-016 o_full / o_empty  output  1 each  o_count==DEPTH / o_count==0.

Function
REQ-017 State SHALL be: head pointer, tail pointer (both IDX_W, wrapping modulo DEPTH), count, and per-entry valid and complete bits.
REQ-018 Allocation grants SHALL be combinational from registered state only: free = DEPTH - count, evaluated before any same-cycle retirement.
REQ-019 Requesting lanes SHALL be served in lane order, lane 0 first; each granted lane consumes the next tail index. A lone lane-1 request therefore receives the tail.
REQ-020 A lane SHALL be granted only if enough free entries remain for it and for any lower granted lane. With free==1 and both lanes requesting, only lane 0 is granted.
REQ-021 o_alloc_idx SHALL be {tail, tail+1} whenever exactly lane 0 or both lanes request. With only lane 1 requesting, o_alloc_idx[1] SHALL be tail. Values SHALL wrap modulo DEPTH.
REQ-022 On the clock edge, each granted entry SHALL be set valid with complete cleared. Tail SHALL advance by the number of grants.
REQ-023 Completion: on each clock edge, for every port with i_cmpl_valid set and a valid target entry, complete SHALL be set. Completions to invalid entries SHALL be ignored. Duplicate indices across ports are legal and idempotent.
REQ-024 o_retire_valid[0] SHALL be valid[head] & complete[head] & !i_retire_stall, combinational from registered state.
REQ-025 o_retire_valid[1] SHALL be o_retire_valid[0] & valid[head+1] & complete[head+1]. o_retire_idx SHALL be {head, head+1}.
REQ-026 Retirement SHALL be strictly in order: a completed entry is never retired while an older entry is incomplete.
REQ-027 On the edge, retired entries SHALL clear valid and complete, and head SHALL advance by the retire count.
REQ-028 Completion-to-retire latency SHALL be one cycle: a completion captured at edge N makes the entry retirable in the cycle following edge N, never in the same cycle.
REQ-029 Simultaneous allocation and retirement SHALL be legal: count_next = count + grants - retires.
REQ-030 When full, allocation SHALL be refused even if a retirement occurs in the same cycle.
REQ-031 i_flush SHALL force o_alloc_gnt=0 and o_retire_valid=0 in that cycle. At the edge it SHALL clear all valid and complete bits and set head=tail=count=0, overriding same-cycle completions.
REQ-032 Priority SHALL be i_rst > i_flush > normal operation.

Reset
REQ-033 On i_rst at a clock edge: head=0, tail=0, count=0, and all valid and complete bits = 0.
REQ-034 While i_rst is asserted, o_alloc_gnt and o_retire_valid SHALL be 0.
REQ-035 After reset: o_empty=1, o_full=0, o_count=0, o_alloc_idx={0,1}, o_retire_idx={0,1}.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight entries within one edge, with no retire strobe.

Verification
REQ-037 Reset, then idle -> o_empty=1, o_count=0, o_alloc_idx={0,1}, o_retire_valid=00.
REQ-038 i_alloc_req=11 for 8 cycles -> indices 0..15 granted in order, o_full=1. A 9th request -> o_alloc_gnt=00.
REQ-039 Allocate 0,1; complete idx 1 only -> o_retire_valid=00. Complete idx 0 -> next cycle o_retire_valid=11, o_retire_idx={0,1}, o_count decreases by 2.
REQ-040 Count 15, head=1, tail=0, i_alloc_req=11 -> only lane 0 granted with idx 0. Tail wraps to 1 and o_full=1.
REQ-041 Entries 0,1 complete with i_retire_stall=1 -> o_retire_valid=00 while stalled. Release stall -> retire 0,1 the same cycle.
REQ-042 Count 6 with i_flush=1 plus concurrent i_cmpl_valid and i_alloc_req -> o_alloc_gnt=00. Next cycle o_count=0, o_alloc_idx={0,1}, and no retirement ever occurs for the flushed entries.

Source files
------------

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: tracks head/tail/count plus per-entry valid and
// complete bits. It hands out up to two entries per cycle, accepts
// completions from CMPL_N functional units, and retires up to two entries
// per cycle in program order.
//
// Handshake semantics: alloc is request/grant in the same cycle. A lane's
// entry is taken at the clock edge exactly when o_alloc_gnt for that lane is
// high. Retirement is a strobe: o_retire_valid[k] high means the entry at
// o_retire_idx[k] leaves the buffer at this edge. The commit side holds it
// back with i_retire_stall. Completions are fire-and-forget strobes.
// Lane/slot k occupies bits [k*IDX_W +: IDX_W] of the packed index buses.
module rob_ctrl #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int CMPL_N = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic [1:0]              i_alloc_req,
  output logic [1:0]              o_alloc_gnt,
  output logic [2*IDX_W-1:0]      o_alloc_idx,
  input  logic [CMPL_N-1:0]       i_cmpl_valid,
  input  logic [CMPL_N*IDX_W-1:0] i_cmpl_idx,
  input  logic                    i_retire_stall,
  output logic [1:0]              o_retire_valid,
  output logic [2*IDX_W-1:0]      o_retire_idx,
  output logic [IDX_W:0]          o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] complete_q, complete_d;

  logic             block;
  logic [IDX_W:0]   free_cnt;
  logic [IDX_W:0]   need_lane1;
  logic             gnt0, gnt1;
  logic [IDX_W-1:0] alloc_idx0, alloc_idx1;
  logic [IDX_W-1:0] head_p1;
  logic             ret0, ret1;
  logic [1:0]       n_gnt, n_ret;

  // Grants and retire strobes, purely from registered state; reset and flush
  // suppress both so nothing is handed out or committed in those cycles.
  always_comb begin
    block      = i_rst | i_flush;
    free_cnt   = DEPTH_CNT - count_q;
    gnt0       = ~block & i_alloc_req[0] & (free_cnt != '0);
    need_lane1 = gnt0 ? (IDX_W+1)'(2) : (IDX_W+1)'(1);
    gnt1       = ~block & i_alloc_req[1] & (free_cnt >= need_lane1);
    alloc_idx0 = tail_q;
    // A lone lane-1 request takes the tail itself rather than tail+1.
    alloc_idx1 = (i_alloc_req == 2'b10) ? tail_q : tail_q + IDX_W'(1);
    head_p1    = head_q + IDX_W'(1);
    ret0       = ~block & ~i_retire_stall & valid_q[head_q] & complete_q[head_q];
    ret1       = ret0 & valid_q[head_p1] & complete_q[head_p1];
    n_gnt      = {1'b0, gnt0} + {1'b0, gnt1};
    n_ret      = {1'b0, ret0} + {1'b0, ret1};
  end

  // Next-state: completions, then retire clears, then allocation sets;
  // flush overrides all of it.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    complete_d = complete_q;
    if (i_flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      valid_d    = '0;
      complete_d = '0;
    end else begin
      for (int p = 0; p < CMPL_N; p++) begin
        if (i_cmpl_valid[p] && valid_q[i_cmpl_idx[p*IDX_W +: IDX_W]]) begin
          complete_d[i_cmpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
        end
      end
      if (ret0) begin
        valid_d[head_q]    = 1'b0;
        complete_d[head_q] = 1'b0;
      end
      if (ret1) begin
        valid_d[head_p1]    = 1'b0;
        complete_d[head_p1] = 1'b0;
      end
      if (gnt0) begin
        valid_d[alloc_idx0]    = 1'b1;
        complete_d[alloc_idx0] = 1'b0;
      end
      if (gnt1) begin
        valid_d[alloc_idx1]    = 1'b1;
        complete_d[alloc_idx1] = 1'b0;
      end
      head_d  = head_q + IDX_W'(n_ret);
      tail_d  = tail_q + IDX_W'(n_gnt);
      count_d = count_q + (IDX_W+1)'(n_gnt) - (IDX_W+1)'(n_ret);
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
    end
  end

  assign o_alloc_gnt    = {gnt1, gnt0};
  assign o_alloc_idx    = {alloc_idx1, alloc_idx0};
  assign o_retire_valid = {ret1, ret0};
  assign o_retire_idx   = {head_p1, head_q};
  assign o_count        = count_q;
  assign o_full         = (count_q == DEPTH_CNT);
  assign o_empty        = (count_q == '0);

endmodule

// File: tb/tb_rob_ctrl.sv
// Directed bench for rob_ctrl. Inputs change 1 time unit after a rising
// edge; outputs are checked 1 unit later, well before the next edge.
module tb_rob_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  alloc_req;
  logic [1:0]  alloc_gnt;
  logic [7:0]  alloc_idx;
  logic [2:0]  cmpl_valid;
  logic [11:0] cmpl_idx;
  logic        retire_stall;
  logic [1:0]  retire_valid;
  logic [7:0]  retire_idx;
  logic [4:0]  count;
  logic        full;
  logic        empty;

  int n_cmp = 0;
  int n_bad = 0;

  rob_ctrl #(.DEPTH(16), .IDX_W(4), .CMPL_N(3)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flush        (flush),
    .i_alloc_req    (alloc_req),
    .o_alloc_gnt    (alloc_gnt),
    .o_alloc_idx    (alloc_idx),
    .i_cmpl_valid   (cmpl_valid),
    .i_cmpl_idx     (cmpl_idx),
    .i_retire_stall (retire_stall),
    .o_retire_valid (retire_valid),
    .o_retire_idx   (retire_idx),
    .o_count        (count),
    .o_full         (full),
    .o_empty        (empty)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    flush        = 1'b0;
    alloc_req    = 2'b00;
    cmpl_valid   = 3'b000;
    cmpl_idx     = '0;
    retire_stall = 1'b0;
  endtask

  // Advance one edge; inputs stay as set. Leaves time 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_cmpl(input int port, input logic [3:0] idx);
    cmpl_valid[port]       = 1'b1;
    cmpl_idx[port*4 +: 4]  = idx;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    drive_idle();
    rst       = 1'b1;
    alloc_req = 2'b11;
    tick();
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL rst_gnt got %b exp 00", alloc_gnt); end
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL rst_rv got %b exp 00", retire_valid); end
    rst       = 1'b0;
    alloc_req = 2'b00;
    settle();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty got %b exp 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full got %b exp 0", full); end
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if (alloc_idx !== 8'h10) begin n_bad++; $display("FAIL rst_alloc_idx got %h exp 10", alloc_idx); end
    n_cmp++; if (retire_idx !== 8'h10) begin n_bad++; $display("FAIL rst_retire_idx got %h exp 10", retire_idx); end
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL rst_idle_rv got %b exp 00", retire_valid); end
  endtask

  // Fill, wrap with free==1, and refuse allocation when full despite a retire.
  task automatic test_fill_wrap();
    logic [3:0] lo, hi;
    do_reset();
    alloc_req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      settle();
      lo = 4'(2 * i);
      hi = 4'(2 * i + 1);
      n_cmp++; if (alloc_gnt !== 2'b11) begin n_bad++; $display("FAIL fill_gnt[%0d] got %b exp 11", i, alloc_gnt); end
      n_cmp++; if (alloc_idx !== {hi, lo}) begin n_bad++; $display("FAIL fill_idx[%0d] got %h exp %h", i, alloc_idx, {hi, lo}); end
      tick();
    end
    settle();
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full got %b exp 1", full); end
    n_cmp++; if (count !== 5'd16) begin n_bad++; $display("FAIL fill_count got %0d exp 16", count); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL fill_9th_gnt got %b exp 00", alloc_gnt); end
    // Complete entry 0, retire it -> head=1, tail=0, count=15.
    alloc_req = 2'b00;
    set_cmpl(0, 4'd0);
    settle();
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL cmpl_same_cycle_rv got %b exp 00", retire_valid); end
    tick();
    drive_idle();
    settle();
    n_cmp++; if (retire_valid !== 2'b01) begin n_bad++; $display("FAIL wrap_rv got %b exp 01", retire_valid); end
    tick();
    n_cmp++; if (count !== 5'd15) begin n_bad++; $display("FAIL wrap_count got %0d exp 15", count); end
    n_cmp++; if (retire_idx !== 8'h21) begin n_bad++; $display("FAIL wrap_retire_idx got %h exp 21", retire_idx); end
    alloc_req = 2'b11;
    settle();
    n_cmp++; if (alloc_gnt !== 2'b01) begin n_bad++; $display("FAIL wrap_gnt got %b exp 01", alloc_gnt); end
    n_cmp++; if (alloc_idx !== 8'h10) begin n_bad++; $display("FAIL wrap_idx got %h exp 10", alloc_idx); end
    tick();
    alloc_req = 2'b00;
    settle();
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL wrap_full got %b exp 1", full); end
    n_cmp++; if (alloc_idx !== 8'h21) begin n_bad++; $display("FAIL wrap_tail got %h exp 21", alloc_idx); end
    // Full with a retire in the same cycle: allocation still refused.
    set_cmpl(1, 4'd1);
    tick();
    drive_idle();
    alloc_req = 2'b11;
    settle();
    n_cmp++; if (retire_valid !== 2'b01) begin n_bad++; $display("FAIL full_retire_rv got %b exp 01", retire_valid); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL full_retire_gnt got %b exp 00", alloc_gnt); end
    tick();
    alloc_req = 2'b00;
    settle();
    n_cmp++; if (count !== 5'd15) begin n_bad++; $display("FAIL full_retire_count got %0d exp 15", count); end
  endtask

  // In-order retirement and the lone lane-1 request.
  task automatic test_in_order();
    do_reset();
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b00;
    set_cmpl(1, 4'd1);
    tick();
    cmpl_valid = '0;
    settle();
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL order_young_only_rv got %b exp 00", retire_valid); end
    // Same index on two ports is harmless.
    set_cmpl(0, 4'd0);
    set_cmpl(2, 4'd0);
    tick();
    cmpl_valid = '0;
    settle();
    n_cmp++; if (retire_valid !== 2'b11) begin n_bad++; $display("FAIL order_rv got %b exp 11", retire_valid); end
    n_cmp++; if (retire_idx !== 8'h10) begin n_bad++; $display("FAIL order_retire_idx got %h exp 10", retire_idx); end
    tick();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL order_count got %0d exp 0", count); end
    // head=tail=2; lone lane-1 request takes the tail.
    alloc_req = 2'b10;
    settle();
    n_cmp++; if (alloc_gnt !== 2'b10) begin n_bad++; $display("FAIL lane1_gnt got %b exp 10", alloc_gnt); end
    n_cmp++; if (alloc_idx[7:4] !== 4'd2) begin n_bad++; $display("FAIL lane1_idx got %0d exp 2", alloc_idx[7:4]); end
    tick();
    alloc_req = 2'b00;
    set_cmpl(2, 4'd2);
    tick();
    cmpl_valid = '0;
    settle();
    n_cmp++; if (retire_valid !== 2'b01) begin n_bad++; $display("FAIL lane1_rv got %b exp 01", retire_valid); end
    n_cmp++; if (retire_idx !== 8'h32) begin n_bad++; $display("FAIL lane1_retire_idx got %h exp 32", retire_idx); end
  endtask

  task automatic test_stall();
    do_reset();
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b00;
    set_cmpl(0, 4'd0);
    set_cmpl(1, 4'd1);
    retire_stall = 1'b1;
    tick();
    cmpl_valid = '0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL stall_rv[%0d] got %b exp 00", i, retire_valid); end
      tick();
    end
    n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL stall_count got %0d exp 2", count); end
    retire_stall = 1'b0;
    settle();
    n_cmp++; if (retire_valid !== 2'b11) begin n_bad++; $display("FAIL unstall_rv got %b exp 11", retire_valid); end
    tick();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL unstall_empty got %b exp 1", empty); end
  endtask

  // Allocate and retire in the same cycle.
  task automatic test_back_to_back();
    do_reset();
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b00;
    set_cmpl(0, 4'd0);
    set_cmpl(1, 4'd1);
    tick();
    cmpl_valid = '0;
    alloc_req  = 2'b11;
    settle();
    n_cmp++; if (alloc_gnt !== 2'b11) begin n_bad++; $display("FAIL b2b_gnt got %b exp 11", alloc_gnt); end
    n_cmp++; if (alloc_idx !== 8'h32) begin n_bad++; $display("FAIL b2b_idx got %h exp 32", alloc_idx); end
    n_cmp++; if (retire_valid !== 2'b11) begin n_bad++; $display("FAIL b2b_rv got %b exp 11", retire_valid); end
    tick();
    alloc_req = 2'b00;
    settle();
    n_cmp++; if (count !== 5'd2) begin n_bad++; $display("FAIL b2b_count got %0d exp 2", count); end
    n_cmp++; if (retire_idx !== 8'h32) begin n_bad++; $display("FAIL b2b_head got %h exp 32", retire_idx); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_req = 2'b11;
    for (int i = 0; i < 3; i++) tick();
    alloc_req = 2'b00;
    set_cmpl(0, 4'd0);
    tick();
    cmpl_valid = '0;
    settle();
    n_cmp++; if (count !== 5'd6) begin n_bad++; $display("FAIL flush_pre_count got %0d exp 6", count); end
    flush     = 1'b1;
    alloc_req = 2'b11;
    set_cmpl(1, 4'd1);
    settle();
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL flush_gnt got %b exp 00", alloc_gnt); end
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL flush_rv got %b exp 00", retire_valid); end
    tick();
    drive_idle();
    settle();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL flush_count got %0d exp 0", count); end
    n_cmp++; if (alloc_idx !== 8'h10) begin n_bad++; $display("FAIL flush_alloc_idx got %h exp 10", alloc_idx); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL flush_idle_rv[%0d] got %b exp 00", i, retire_valid); end
      tick();
    end
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b00;
    settle();
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL flush_realloc_rv got %b exp 00", retire_valid); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    alloc_req = 2'b11;
    tick();
    alloc_req = 2'b00;
    set_cmpl(0, 4'd0);
    set_cmpl(1, 4'd1);
    tick();
    cmpl_valid = '0;
    rst        = 1'b1;
    alloc_req  = 2'b11;
    settle();
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL midrst_rv got %b exp 00", retire_valid); end
    n_cmp++; if (alloc_gnt !== 2'b00) begin n_bad++; $display("FAIL midrst_gnt got %b exp 00", alloc_gnt); end
    tick();
    rst       = 1'b0;
    alloc_req = 2'b00;
    settle();
    n_cmp++; if (count !== 5'd0) begin n_bad++; $display("FAIL midrst_count got %0d exp 0", count); end
    n_cmp++; if (retire_valid !== 2'b00) begin n_bad++; $display("FAIL midrst_after_rv got %b exp 00", retire_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_fill_wrap();
    test_in_order();
    test_stall();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
